vector_sweep_checker: RTL
=========================

Name: vector_sweep_checker

Overview:
- Self-checking exhaustive stimulus engine for small combinational circuits under test (CUT).
- Drives every one of the 2^N_IN input combinations onto the CUT and holds each for a programmable settle time.
- Samples the CUT output, compares it against a golden-model output and accumulates pass/fail results.
- Sits between a CUT and its golden reference; replaces hand-sequenced delay/display benches with a clocked, parametrised checker.

Parameters:
N_IN, 3, number of CUT inputs; the sweep covers 2^N_IN vectors; legal range 1..16.
N_OUT, 1, number of CUT outputs compared.
SETTLE_CYCLES, 7, clock cycles each vector is held before sampling; legal minimum 1.
GRAY_ORDER, 0, vector order: 0 = binary count, 1 = reflected Gray (one input toggles per step).

Ports:
clk  input  1  clock; all logic on the rising edge.
rst_n  input  1  synchronous active-low reset.
start  input  1  begin a sweep; sampled only in IDLE.
abort  input  1  synchronous stop of a sweep in progress.
loop_en  input  1  when 1, restart automatically after each completed sweep.
stim  output  N_IN  registered vector driven to the CUT and the golden model.
dut_out  input  N_OUT  CUT output.
exp_out  input  N_OUT  golden-model output for the current stim.
busy  output  1  high in SETTLE and SAMPLE.
sample_valid  output  1  one-cycle pulse per checked vector.
sample_idx  output  N_IN  sweep index of the vector just checked.
sample_data  output  N_OUT  dut_out captured for that vector.
mismatch_count  output  N_IN+1  mismatches in the current or last sweep; cannot overflow.
first_fail_valid  output  1  at least one mismatch in this sweep.
first_fail_idx  output  N_IN  sweep index of the first mismatch.
done  output  1  one-cycle pulse at sweep completion.
pass  output  1  registered with done: 1 iff mismatch_count==0; held until the next sweep starts.

Behaviour:
- Reset (rst_n=0 at an edge): state IDLE; stim, the counters and every output are 0.
- FSM states: IDLE, SETTLE, SAMPLE.
- IDLE, start=1 at an edge:
  - idx<=0 and stim<=vec(0).
  - Settle counter <= SETTLE_CYCLES-1, state <= SETTLE.
  - mismatch_count, first_fail_valid, first_fail_idx and pass cleared.
- SETTLE: the counter decrements each edge; at count 0 the next state is SAMPLE.
- SAMPLE (exactly one cycle); at its edge:
  - sample_valid<=1, sample_idx<=idx, sample_data<=dut_out.
  - If dut_out!=exp_out: mismatch_count++. If first_fail_valid was 0, set it to 1 and capture first_fail_idx<=idx.
  - If idx < 2^N_IN-1: idx++, stim<=vec(idx+1), counter reloaded, state <= SETTLE.
  - Else: done<=1 and pass<=(final count==0).
    - loop_en=0: state <= IDLE and stim holds the last vector.
    - loop_en=1: behave as a fresh start in the same edge (counters cleared, vec(0) applied). The done, pass, sample_valid, mismatch_count and first_fail_* of the finished sweep are all visible for the one cycle after that edge, so the clear takes effect one edge later.
- Timing:
  - Each vector is held SETTLE_CYCLES+1 cycles.
  - sample_valid for vector k occurs (k+1)*(SETTLE_CYCLES+1) edges after the start edge.
  - done occurs 2^N_IN*(SETTLE_CYCLES+1) edges after the start edge.
- Vector function:
  - vec(i) = i when GRAY_ORDER=0.
  - vec(i) = i ^ (i>>1) when GRAY_ORDER=1.
  - sample_idx and first_fail_idx always report i, not vec(i).
- start while busy: ignored.
- start and abort in the same IDLE cycle: abort wins, nothing starts.
- abort while busy: next edge state <= IDLE, stim <= 0, no done and no sample_valid. Counters keep their partial values; pass stays 0.
- rst_n=0 mid-sweep: full reset, no pulses.
- Precedence: rst_n > abort > start.
- exp_out is compared combinationally in the SAMPLE cycle. The golden model must be purely combinational in stim.

Decomposition:
- Package vector_sweep_pkg: the state enum (IDLE/SETTLE/SAMPLE) and the bin2gray function.
- Sub-module sweep_settle_timer: a loadable down-counter with a zero flag, width $clog2(SETTLE_CYCLES+1).
- Everything else stays in the top level.

Test Plan:
- Defaults; CUT = golden = 3-input majority; start at edge 0 -> 8 sample_valid pulses at edges 8,16,…,64 with sample_idx 0..7; done at edge 64; pass=1; mismatch_count=0; first_fail_valid=0.
- CUT forced wrong at vec 5 only -> mismatch_count=1, first_fail_idx=5, first_fail_valid=1, pass=0; then a wrong 3 as well -> count=2, first_fail_idx stays 3.
- GRAY_ORDER=1 -> stim sequence 0,1,3,2,6,7,5,4, each stable for 8 cycles; sample_idx still 0..7.
- abort at edge 20 -> IDLE next edge, stim=0, no done, busy=0; a new start then completes normally in 64 cycles with counters cleared.
- loop_en=1, CUT fault at vec 2 -> done pulses every 64 cycles; mismatch_count reads 1 at each done and never accumulates to 2.
- start pulsed at edge 10 during a sweep, and rst_n=0 at edge 30 -> start has no effect; reset forces all outputs to 0 with no done; SETTLE_CYCLES=1, N_IN=4 sweep -> done at edge 32.

Source files
------------

// File: rtl/vector_sweep_pkg.sv
// Shared types and helpers for the exhaustive vector sweep checker.
package vector_sweep_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSettle = 2'd1,
        StSample = 2'd2
    } sweep_state_e;

    localparam int unsigned VecMaxW = 16;

    function automatic logic [VecMaxW-1:0] bin2gray(input logic [VecMaxW-1:0] i_bin);
        return i_bin ^ (i_bin >> 1);
    endfunction

endpackage

// File: rtl/sweep_settle_timer.sv
// Loadable down-counter that parks at zero; o_zero marks the end of a settle window.
module sweep_settle_timer #(
    parameter int unsigned Width = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [Width-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [Width-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && !o_zero) begin
            r_count <= r_count - Width'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/vector_sweep_checker.sv
// Exhaustive stimulus engine: walks all 2^N_IN vectors, holds each for a settle window,
// then compares the CUT against its golden model and accumulates the sweep verdict.
module vector_sweep_checker
    import vector_sweep_pkg::*;
#(
    parameter int unsigned N_IN          = 3,
    parameter int unsigned N_OUT         = 1,
    parameter int unsigned SETTLE_CYCLES = 7,
    parameter int unsigned GRAY_ORDER    = 0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_loop_en,
    output logic [N_IN-1:0]  o_stim,
    input  logic [N_OUT-1:0] i_dut_out,
    input  logic [N_OUT-1:0] i_exp_out,
    output logic             o_busy,
    output logic             o_sample_valid,
    output logic [N_IN-1:0]  o_sample_idx,
    output logic [N_OUT-1:0] o_sample_data,
    output logic [N_IN:0]    o_mismatch_count,
    output logic             o_first_fail_valid,
    output logic [N_IN-1:0]  o_first_fail_idx,
    output logic             o_done,
    output logic             o_pass
);

    localparam int unsigned     CntW         = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CntW-1:0] SettleReload = CntW'(SETTLE_CYCLES - 1);
    localparam logic [N_IN-1:0] IdxLast      = '1;

    sweep_state_e r_state, w_state_next;

    logic [N_IN-1:0]  r_idx;
    logic [N_IN-1:0]  r_stim;
    logic             r_sample_valid;
    logic [N_IN-1:0]  r_sample_idx;
    logic [N_OUT-1:0] r_sample_data;
    logic [N_IN:0]    r_mismatch_count;
    logic             r_ff_valid;
    logic [N_IN-1:0]  r_ff_idx;
    logic             r_done;
    logic             r_pass;
    logic             r_clear_pending;

    logic             w_settle_zero;
    logic             w_settle_dec;
    logic             w_timer_load;
    logic             w_accept;
    logic             w_advance;
    logic             w_last;
    logic             w_mis;
    logic [N_IN-1:0]  w_idx_inc;
    logic [N_IN-1:0]  w_vec_next;
    logic [N_IN:0]    w_count_next;

    sweep_settle_timer #(
        .Width (CntW)
    ) u_settle_timer (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_timer_load),
        .i_load_val (SettleReload),
        .i_dec      (w_settle_dec),
        .o_zero     (w_settle_zero)
    );

    assign w_last       = (r_idx == IdxLast);
    assign w_mis        = (i_dut_out != i_exp_out);
    assign w_count_next = r_mismatch_count + (N_IN + 1)'(w_mis);
    // Index wraps to 0 after the last vector, so a loop restart reuses the same path.
    assign w_idx_inc    = r_idx + N_IN'(1);
    assign w_vec_next   = (GRAY_ORDER != 0) ? N_IN'(bin2gray(VecMaxW'(w_idx_inc))) : w_idx_inc;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (i_start && !i_abort) w_state_next = StSettle;
            end
            StSettle: begin
                if (i_abort)            w_state_next = StIdle;
                else if (w_settle_zero) w_state_next = StSample;
            end
            StSample: begin
                if (i_abort)                   w_state_next = StIdle;
                else if (!w_last || i_loop_en) w_state_next = StSettle;
                else                           w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        o_busy       = (r_state != StIdle);
        w_settle_dec = (r_state == StSettle);
        w_accept     = (r_state == StIdle) && i_start && !i_abort;
        w_advance    = (r_state == StSample) && !i_abort;
        w_timer_load = w_accept || (w_advance && (!w_last || i_loop_en));
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_idx            <= '0;
            r_stim           <= '0;
            r_sample_valid   <= 1'b0;
            r_sample_idx     <= '0;
            r_sample_data    <= '0;
            r_mismatch_count <= '0;
            r_ff_valid       <= 1'b0;
            r_ff_idx         <= '0;
            r_done           <= 1'b0;
            r_pass           <= 1'b0;
            r_clear_pending  <= 1'b0;
        end else begin
            r_sample_valid  <= 1'b0;
            r_done          <= 1'b0;
            r_clear_pending <= 1'b0;

            // A looped restart keeps the finished verdict visible for one cycle first.
            if (r_clear_pending || w_accept) begin
                r_mismatch_count <= '0;
                r_ff_valid       <= 1'b0;
                r_ff_idx         <= '0;
                r_pass           <= 1'b0;
            end

            if (w_accept) begin
                r_idx  <= '0;
                r_stim <= '0;
            end

            if (i_abort && o_busy) begin
                r_stim <= '0;
            end

            if (w_advance) begin
                r_sample_valid   <= 1'b1;
                r_sample_idx     <= r_idx;
                r_sample_data    <= i_dut_out;
                r_mismatch_count <= w_count_next;
                if (w_mis && !r_ff_valid) begin
                    r_ff_valid <= 1'b1;
                    r_ff_idx   <= r_idx;
                end
                r_idx <= w_idx_inc;
                if (!w_last || i_loop_en) begin
                    r_stim <= w_vec_next;
                end
                if (w_last) begin
                    r_done          <= 1'b1;
                    r_pass          <= (w_count_next == '0);
                    r_clear_pending <= i_loop_en;
                end
            end
        end
    end

    assign o_stim             = r_stim;
    assign o_sample_valid     = r_sample_valid;
    assign o_sample_idx       = r_sample_idx;
    assign o_sample_data      = r_sample_data;
    assign o_mismatch_count   = r_mismatch_count;
    assign o_first_fail_valid = r_ff_valid;
    assign o_first_fail_idx   = r_ff_idx;
    assign o_done             = r_done;
    assign o_pass             = r_pass;

endmodule
